bp_me_io_load_arbiter: RTL and testbench

//  Merges num_chan_p independent io command masters (nbf loader, cce cfg loader, debug/host injectors)

---
 rtl/bp_me_io_load_arbiter.sv | 100 ++++++++++
 tb/tb_bp_me_io_load_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bp_me_io_load_arbiter.sv
// bp_me_io_load_arbiter: N-way io command arbiter with in-order response steering via a source-ID FIFO.
// Optional per-channel accepted-command counters under `BP_IO_ARB_CMD_COUNT_EN.
module bp_me_io_load_arbiter #(
    parameter int num_chan_p        = 2,
    parameter int msg_width_p       = 64,
    parameter int max_outstanding_p = 8,
    parameter int rr_p              = 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_chan_p*msg_width_p-1:0]      io_cmd_i,
    input  logic [num_chan_p-1:0]                  io_cmd_v_i,
    output logic [num_chan_p-1:0]                  io_cmd_ready_o,
    output logic [msg_width_p-1:0]                 io_resp_o,
    output logic [num_chan_p-1:0]                  io_resp_v_o,
    input  logic [num_chan_p-1:0]                  io_resp_ready_i,
    output logic [msg_width_p-1:0]                 load_cmd_o,
    output logic                                   load_cmd_v_o,
    input  logic                                   load_cmd_ready_i,
    input  logic [msg_width_p-1:0]                 load_resp_i,
    input  logic                                   load_resp_v_i,
    output logic                                   load_resp_yumi_o,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   err_o,
    output logic [num_chan_p*32-1:0]               cmd_count_o
);
    localparam int id_w  = num_chan_p > 1 ? $clog2(num_chan_p) : 1;
    localparam int ptr_w = max_outstanding_p > 1 ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_w = $clog2(max_outstanding_p + 1);

    logic [id_w-1:0]  gnt, search, cand, last_grant_r, held_r, head;
    logic             hold_r, full, empty, push, pop;
    logic [id_w-1:0]  fifo_r [max_outstanding_p];
    logic [ptr_w-1:0] wr_ptr_r, rd_ptr_r;
    logic [cnt_w-1:0] count_r;

    assign full  = count_r == cnt_w'(max_outstanding_p);
    assign empty = count_r == '0;

    // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
    always_comb begin
        search = '0;
        cand   = '0;
        for (int i = num_chan_p - 1; i >= 0; i--) begin
            cand = id_w'(rr_p != 0 ? (int'(last_grant_r) + 1 + i) % num_chan_p : i);
            if (io_cmd_v_i[cand]) search = cand;
        end
    end

    assign gnt              = hold_r ? held_r : search;
    assign load_cmd_v_o     = reset_n_i & io_cmd_v_i[gnt] & ~full;
    assign load_cmd_o       = io_cmd_i[int'(gnt)*msg_width_p +: msg_width_p];
    assign io_cmd_ready_o   = (num_chan_p'(1) << gnt) & {num_chan_p{reset_n_i & load_cmd_ready_i & ~full}};
    assign head             = fifo_r[rd_ptr_r];
    assign io_resp_o        = load_resp_i;
    assign io_resp_v_o      = (num_chan_p'(1) << head) & {num_chan_p{reset_n_i & load_resp_v_i & ~empty}};
    assign load_resp_yumi_o = reset_n_i & load_resp_v_i & (empty | io_resp_ready_i[head]);
    assign push             = load_cmd_v_o & load_cmd_ready_i;
    assign pop              = load_resp_yumi_o & ~empty;
    assign outstanding_o    = count_r;

    always_ff @(posedge clk_i) begin
        if (push) fifo_r[wr_ptr_r] <= gnt;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_r       <= 1'b0;
            held_r       <= '0;
            last_grant_r <= id_w'(num_chan_p - 1);
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            err_o        <= 1'b0;
        end else begin
            hold_r   <= load_cmd_v_o & ~load_cmd_ready_i;
            held_r   <= gnt;
            count_r  <= count_r + cnt_w'(push) - cnt_w'(pop);
            if (push) last_grant_r <= gnt;
            if (push) wr_ptr_r <= wr_ptr_r == ptr_w'(max_outstanding_p - 1) ? '0 : wr_ptr_r + ptr_w'(1);
            if (pop) rd_ptr_r <= rd_ptr_r == ptr_w'(max_outstanding_p - 1) ? '0 : rd_ptr_r + ptr_w'(1);
            if (load_resp_v_i & empty) err_o <= 1'b1;
        end
    end

`ifdef BP_IO_ARB_CMD_COUNT_EN
    logic [31:0] cnt_r [num_chan_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_r <= '{default: '0};
        else if (push) cnt_r[gnt] <= cnt_r[gnt] + 32'd1;
    end

    for (genvar c = 0; c < num_chan_p; c++) begin : g_cnt
        assign cmd_count_o[c*32 +: 32] = cnt_r[c];
    end
`else
    assign cmd_count_o = '0;
`endif
endmodule

// File: tb/tb_bp_me_io_load_arbiter.sv
// tb_bp_me_io_load_arbiter: random traffic on a 3-channel round-robin arbiter checked against a queue model,
// plus a short fixed-priority starvation check on a second instance.
module tb_bp_me_io_load_arbiter;
    localparam int N = 3, W = 16, D = 4;
`ifdef BP_IO_ARB_CMD_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic           clk = 1'b0, rst_n = 1'b0;
    logic [N*W-1:0] cmd;
    logic [N-1:0]   cmd_v, cmd_ready, resp_v_o, resp_ready;
    logic [W-1:0]   resp, lcmd, lresp;
    logic           lcmd_v, lcmd_ready, lresp_v, yumi, err;
    logic [2:0]     outst;
    logic [N*32-1:0] cnt;

    logic [2*W-1:0] fp_cmd;
    logic [1:0]     fp_v, fp_ready, fp_resp_v, fp_resp_ready;
    logic [W-1:0]   fp_resp, fp_lcmd, fp_lresp;
    logic           fp_lcmd_v, fp_lready, fp_lresp_v, fp_yumi, fp_err;
    logic [3:0]     fp_outst;
    logic [63:0]    fp_cnt;

    always #5 clk = ~clk;

    bp_me_io_load_arbiter #(.num_chan_p(N), .msg_width_p(W), .max_outstanding_p(D), .rr_p(1)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .io_cmd_i(cmd), .io_cmd_v_i(cmd_v), .io_cmd_ready_o(cmd_ready),
        .io_resp_o(resp), .io_resp_v_o(resp_v_o), .io_resp_ready_i(resp_ready), .load_cmd_o(lcmd),
        .load_cmd_v_o(lcmd_v), .load_cmd_ready_i(lcmd_ready), .load_resp_i(lresp), .load_resp_v_i(lresp_v),
        .load_resp_yumi_o(yumi), .outstanding_o(outst), .err_o(err), .cmd_count_o(cnt));

    bp_me_io_load_arbiter #(.num_chan_p(2), .msg_width_p(W), .max_outstanding_p(8), .rr_p(0)) fp (
        .clk_i(clk), .reset_n_i(rst_n), .io_cmd_i(fp_cmd), .io_cmd_v_i(fp_v), .io_cmd_ready_o(fp_ready),
        .io_resp_o(fp_resp), .io_resp_v_o(fp_resp_v), .io_resp_ready_i(fp_resp_ready), .load_cmd_o(fp_lcmd),
        .load_cmd_v_o(fp_lcmd_v), .load_cmd_ready_i(fp_lready), .load_resp_i(fp_lresp), .load_resp_v_i(fp_lresp_v),
        .load_resp_yumi_o(fp_yumi), .outstanding_o(fp_outst), .err_o(fp_err), .cmd_count_o(fp_cnt));

    int total = 0, passes = 0, fails = 0;
    int last, held_ch, q[$];
    bit held, merr, v[N];
    int unsigned mcnt[N];
    logic [W-1:0] d[N];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last = N - 1;
        held = 0;
        held_ch = 0;
        merr = 0;
        for (int c = 0; c < N; c++) begin
            v[c] = 0;
            mcnt[c] = 0;
        end
    endtask

    task automatic idle_inputs();
        cmd_v = '0;
        cmd = '0;
        lcmd_ready = 1'b0;
        lresp_v = 1'b0;
        lresp = '0;
        resp_ready = '0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_cmd_v"}, 64'(lcmd_v), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        check({tag, "_resp_v"}, 64'(resp_v_o), 64'd0);
        check({tag, "_yumi"}, 64'(yumi), 64'd0);
        check({tag, "_outstanding"}, 64'(outst), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_count"}, 64'(cnt), 64'd0);
    endtask

    task automatic cycle();
        int g, head;
        bit full, empty, ev;
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            if (!v[c]) begin
                v[c] = $urandom_range(0, 99) < 45;
                d[c] = W'($urandom);
            end
            cmd_v[c] = v[c];
            cmd[c*W +: W] = d[c];
        end
        lcmd_ready = $urandom_range(0, 99) < 65;
        lresp_v = $urandom_range(0, 99) < 40;
        lresp = W'($urandom);
        resp_ready = N'($urandom);
        #1;
        full = q.size() == D;
        empty = q.size() == 0;
        g = -1;
        if (held) g = held_ch;
        else for (int i = 0; i < N && g < 0; i++) if (v[(last + 1 + i) % N]) g = (last + 1 + i) % N;
        ev = g >= 0 && !full;
        check("cmd_v", 64'(lcmd_v), 64'(ev));
        if (ev) check("cmd_data", 64'(lcmd), 64'(d[g]));
        if (g >= 0) check("cmd_ready", 64'(cmd_ready), (lcmd_ready && !full) ? 64'(1) << g : 64'd0);
        head = empty ? 0 : q[0];
        check("resp_v", 64'(resp_v_o), (lresp_v && !empty) ? 64'(1) << head : 64'd0);
        check("yumi", 64'(yumi), 64'(lresp_v && (empty || resp_ready[head])));
        check("resp_data", 64'(resp), 64'(lresp));
        check("outstanding", 64'(outst), 64'(q.size()));
        check("err", 64'(err), 64'(merr));
        for (int c = 0; c < N; c++) check("cmd_count", 64'(cnt[c*32 +: 32]), COUNT_EN ? 64'(mcnt[c]) : 64'd0);
        if (lresp_v && empty) merr = 1;
        if (lresp_v && !empty && resp_ready[head]) void'(q.pop_front());
        if (ev && lcmd_ready) begin
            q.push_back(g);
            last = g;
            mcnt[g]++;
            v[g] = 0;
        end
        held = ev && !lcmd_ready;
        held_ch = g;
    endtask

    initial begin
        model_reset();
        cmd_v = '1;
        cmd = '1;
        lcmd_ready = 1'b1;
        lresp_v = 1'b1;
        lresp = '1;
        resp_ready = '1;
        fp_cmd = {16'hbbbb, 16'haaaa};
        fp_v = 2'b11;
        fp_lready = 1'b1;
        fp_lresp_v = 1'b0;
        fp_lresp = '0;
        fp_resp_ready = 2'b11;
        #13;
        check_reset_outputs("rst");
        check("rst_fp_ready", 64'(fp_ready), 64'd0);
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("fp_cmd_v", 64'(fp_lcmd_v), 64'd1);
            check("fp_ready", 64'(fp_ready), 64'd1);
            check("fp_cmd_data", 64'(fp_lcmd), 64'haaaa);
        end
        fp_v = 2'b00;
        check("fp_outstanding", 64'(fp_outst), 64'd5);
        repeat (400) cycle();
        for (int k = 0; k < 100 && q.size() == 0; k++) cycle();
        check("midflight_nonempty", 64'(q.size() > 0), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) cycle();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
